// File: rtl/h264_pkg.sv
// ----------------------------------------------------------------------------
// h264_pkg
// Shared types and constants for the H.264 bitstream writer.
//   bs_state_e   : bs_writer frame-level FSM states
//   BS_WORD_W    : width of one packed bitstream word (bits)
//   BS_CNT_W     : width of the per-frame written-word counter
//   BS_ADDR_STEP : byte stride between consecutive bitstream words
//   bs_cnt_sat_inc() : saturating increment for the written-word counter
// ----------------------------------------------------------------------------
package h264_pkg;

    localparam int BS_WORD_W    = 32;
    localparam int BS_CNT_W     = 20;
    localparam int BS_ADDR_STEP = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } bs_state_e;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [BS_CNT_W-1:0] bs_cnt_sat_inc(input logic [BS_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, DEPTH entries of WIDTH bits, first-word-fall-through
// (dout always shows the head entry while not empty).
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push     : write din this cycle (ignored when full)
//   pop      : discard the head entry this cycle (ignored when empty)
//   din      : write data
//   dout     : head entry
//   full     : no free entry
//   empty    : no valid entry
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and leaving it unreset lets it map to RAM/LUTRAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bs_writer.sv
// ----------------------------------------------------------------------------
// bs_writer
// Buffers packed bitstream words from the entropy packer and writes them to
// consecutive memory words starting at a per-frame base address.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : frame-start pulse (honoured only in IDLE), samples base_addr
//   base_addr     : byte address of the first word of the frame
//   word_valid    : packer offers word_data
//   word_data     : packed bitstream word
//   word_ready    : word_data accepted this cycle (RUN and buffer not full)
//   frame_end     : packer has no further words (honoured only in RUN)
//   wr_req        : memory write request, held until wr_ack
//   wr_addr       : byte address of the write
//   wr_data       : data of the write
//   wr_ack        : memory accepts the current request
//   words_written : words acknowledged this frame (saturating)
//   busy          : FSM not in IDLE
//   done          : one-cycle pulse once the frame is fully written
// ----------------------------------------------------------------------------
module bs_writer
    import h264_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic                 word_valid,
    input  logic [BS_WORD_W-1:0] word_data,
    output logic                 word_ready,
    input  logic                 frame_end,
    output logic                 wr_req,
    output logic [31:0]          wr_addr,
    output logic [BS_WORD_W-1:0] wr_data,
    input  logic                 wr_ack,
    output logic [BS_CNT_W-1:0]  words_written,
    output logic                 busy,
    output logic                 done
);

    bs_state_e            state;
    bs_state_e            state_next;
    logic [31:0]          addr_q;
    logic [BS_CNT_W-1:0]  count_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [BS_WORD_W-1:0] fifo_dout;
    logic                 push;
    logic                 pop;

    // Request and handshake are pure functions of registered state, so the
    // request stays stable until the ack pops the head, and reset clears it
    // in the same cycle.
    assign word_ready    = (state == RUN) && !fifo_full;
    assign push          = word_valid && word_ready;
    assign wr_req        = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
    assign pop           = wr_req && wr_ack;
    assign wr_addr       = addr_q;
    assign wr_data       = fifo_dout;
    assign words_written = count_q;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    sync_fifo #(
        .WIDTH (BS_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (word_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (frame_end)  state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state <= state_next;
            // Writes only happen in RUN/DRAIN, so the start load and the
            // post-ack advance can never coincide.
            if ((state == IDLE) && start) begin
                addr_q  <= base_addr;
                count_q <= '0;
            end else if (pop) begin
                addr_q  <= addr_q + 32'(BS_ADDR_STEP);
                count_q <= bs_cnt_sat_inc(count_q);
            end
        end
    end

endmodule
